// File: rtl/frame_pkg.sv
// Shared types and widths for the frame sequencer and the draw controller.
package frame_pkg;

   localparam int COORD_W = 10;
   localparam int COLOR_W = 3;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CLEAR      = 3'd1,
      S_DRAW_START = 3'd2,
      S_DRAW_WAIT  = 3'd3,
      S_UPDATE     = 3'd4
   } state_t;

endpackage

// File: rtl/screen_clear_counter.sv
// Raster counter for the clear phase: sweeps (cx,cy) row by row.
// start forces (0,0); advance steps one pixel; last flags the final pixel.
module screen_clear_counter
   import frame_pkg::*;
#(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               advance,
   output logic [COORD_W-1:0] cx,
   output logic [COORD_W-1:0] cy,
   output logic               last
);

   logic row_end;
   logic col_end;

   assign row_end = (cx == COORD_W'(SCREEN_W - 1));
   assign col_end = (cy == COORD_W'(SCREEN_H - 1));
   assign last    = row_end && col_end;

   // Raster position: x runs fastest, wraps into the next row; full wrap after the last pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cx <= '0;
         cy <= '0;
      end else if (start) begin
         cx <= '0;
         cy <= '0;
      end else if (advance) begin
         if (row_end) begin
            cx <= '0;
            cy <= col_end ? '0 : cy + 1'b1;
         end else begin
            cx <= cx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler owning the framebuffer write port.
// Each accepted frame tick runs: clear screen -> start entity draw -> request game update.
//
// Handshakes:
//   draw_start is a one-cycle pulse; draw_done is a one-cycle pulse accepted only in S_DRAW_WAIT.
//   update_req is a level raised on entering S_UPDATE and held until update_ack is sampled high;
//   it drops on the edge that samples the ack.
module frame_sequencer
   import frame_pkg::*;
#(
   parameter int                 SCREEN_W     = 160,
   parameter int                 SCREEN_H     = 120,
   parameter logic [COLOR_W-1:0] BG_COLOR     = 3'b000,
   parameter int                 DRAW_TIMEOUT = 200000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] draw_x,
   input  logic [COORD_W-1:0] draw_y,
   input  logic [COLOR_W-1:0] draw_color,
   input  logic               draw_plot,
   input  logic               draw_done,
   output logic               draw_start,
   output logic               update_req,
   input  logic               update_ack,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [COLOR_W-1:0] color,
   output logic               plot,
   output logic               busy,
   output logic               draw_timeout,
   output logic [7:0]         overrun_count,
   output logic [2:0]         state_dbg
);

   localparam int TW = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;

   state_t             state;
   state_t             next_state;
   logic [COORD_W-1:0] cx;
   logic [COORD_W-1:0] cy;
   logic               clr_last;
   logic [TW-1:0]      timer;
   logic               timer_hit;
   logic               timeout_set;

   assign busy      = (state != S_IDLE);
   assign state_dbg = state;
   assign timer_hit = (timer == TW'(DRAW_TIMEOUT - 1));

   screen_clear_counter #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_clear (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (state == S_IDLE),
      .advance (state == S_CLEAR),
      .cx      (cx),
      .cy      (cy),
      .last    (clr_last)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Next-state logic; draw_done takes priority over the timeout in the same cycle.
   always_comb begin
      next_state  = state;
      timeout_set = 1'b0;
      case (state)
         S_IDLE:       if (frame_tick && enable) next_state = S_CLEAR;
         S_CLEAR:      if (clr_last) next_state = S_DRAW_START;
         S_DRAW_START: next_state = S_DRAW_WAIT;
         S_DRAW_WAIT: begin
            if (draw_done) begin
               next_state = S_UPDATE;
            end else if (timer_hit) begin
               next_state  = S_UPDATE;
               timeout_set = 1'b1;
            end
         end
         S_UPDATE:     if (update_ack) next_state = S_IDLE;
         default:      next_state = S_IDLE;
      endcase
   end

   // Registered write port and control strobes; plot is only ever high after CLEAR or DRAW_WAIT cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x          <= '0;
         y          <= '0;
         color      <= '0;
         plot       <= 1'b0;
         draw_start <= 1'b0;
         update_req <= 1'b0;
      end else begin
         draw_start <= (state == S_DRAW_START);
         update_req <= (next_state == S_UPDATE);
         case (state)
            S_CLEAR: begin
               x     <= cx;
               y     <= cy;
               color <= BG_COLOR;
               plot  <= 1'b1;
            end
            S_DRAW_WAIT: begin
               x     <= draw_x;
               y     <= draw_y;
               color <= draw_color;
               plot  <= draw_plot;
            end
            default: plot <= 1'b0;
         endcase
      end
   end

   // Draw watchdog: cleared when the draw is launched, counts every cycle spent waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   timer <= '0;
      else if (state == S_DRAW_START) timer <= '0;
      else if (state == S_DRAW_WAIT)  timer <= timer + 1'b1;
   end

   // Sticky abort flag and saturating count of ticks that arrived while a frame was running.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         draw_timeout  <= 1'b0;
         overrun_count <= '0;
      end else begin
         if (timeout_set) draw_timeout <= 1'b1;
         if (frame_tick && busy && (overrun_count != 8'hFF))
            overrun_count <= overrun_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a small screen and short draw watchdog.
module tb_frame_sequencer;

   localparam int W = 23;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       frame_tick = 1'b0;
   logic [9:0] draw_x = '0;
   logic [9:0] draw_y = '0;
   logic [2:0] draw_color = '0;
   logic       draw_plot = 1'b0;
   logic       draw_done = 1'b0;
   logic       update_ack = 1'b0;
   logic       draw_start;
   logic       update_req;
   logic [9:0] x;
   logic [9:0] y;
   logic [2:0] color;
   logic       plot;
   logic       busy;
   logic       draw_timeout;
   logic [7:0] overrun_count;
   logic [2:0] state_dbg;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   frame_sequencer #(
      .SCREEN_W     (4),
      .SCREEN_H     (3),
      .BG_COLOR     (3'b000),
      .DRAW_TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .frame_tick    (frame_tick),
      .draw_x        (draw_x),
      .draw_y        (draw_y),
      .draw_color    (draw_color),
      .draw_plot     (draw_plot),
      .draw_done     (draw_done),
      .draw_start    (draw_start),
      .update_req    (update_req),
      .update_ack    (update_ack),
      .x             (x),
      .y             (y),
      .color         (color),
      .plot          (plot),
      .busy          (busy),
      .draw_timeout  (draw_timeout),
      .overrun_count (overrun_count),
      .state_dbg     (state_dbg)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Scoreboard monitor: every framebuffer write must match the next expected pixel.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && plot === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, no write expected at %0t",
                     x, y, color, $time);
         end else begin
            check("plot_pixel", 32'({x, y, color}), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic push_clear(input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({10'(i % 4), 10'(i / 4), 3'b000});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Starts a frame and runs the whole clear; returns on the cycle draw_start is high.
   task automatic run_clear(input int n_extra);
      push_clear(12);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check("busy_after_tick", 32'(busy), 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         frame_tick = (i < 2 * n_extra) && (i % 2 == 0);
      end
      check("last_clear_pixel", 32'({plot, x, y}), 32'({1'b1, 10'd3, 10'd2}));
      check("no_early_draw_start", 32'(draw_start), 32'd0);
      @(negedge clk);
      check("draw_start_pulse", 32'({draw_start, plot}), 32'({1'b1, 1'b0}));
   endtask

   task automatic pulse_done();
      draw_done = 1'b1;
      @(negedge clk);
      draw_done = 1'b0;
      check("update_req_rise", 32'(update_req), 32'd1);
   endtask

   task automatic do_ack(input int hold);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("update_req_held", 32'({update_req, busy}), 32'({1'b1, 1'b1}));
      end
      update_ack = 1'b1;
      @(negedge clk);
      update_ack = 1'b0;
      check("update_req_drop", 32'({update_req, busy}), 32'({1'b0, 1'b0}));
   endtask

   initial begin
      // Reset state.
      @(negedge clk);
      check("reset_outputs", 32'({x, y, color, plot, draw_start, update_req}), 32'd0);
      check("reset_status", 32'({busy, draw_timeout, overrun_count}), 32'd0);
      do_reset();
      enable = 1'b1;

      // Frame A: clear sweep, passthrough, update handshake.
      run_clear(0);
      draw_x = 10'd5; draw_y = 10'd7; draw_color = 3'b101; draw_plot = 1'b1;
      exp_q.push_back({10'd5, 10'd7, 3'b101});
      @(negedge clk);
      check("passthrough", 32'({plot, x, y, color}), 32'({1'b1, 10'd5, 10'd7, 3'b101}));
      draw_x = 10'd9; draw_plot = 1'b0;
      @(negedge clk);
      check("passthrough_noplot", 32'(plot), 32'd0);
      pulse_done();
      do_ack(10);
      draw_plot = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_draw_plot_blocked", 32'(plot), 32'd0);
      draw_plot = 1'b0;
      draw_done = 1'b1;
      @(negedge clk);
      draw_done = 1'b0;
      check("idle_draw_done_ignored", 32'({busy, update_req}), 32'd0);
      enable = 1'b0;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check("tick_while_disabled", 32'(busy), 32'd0);
      enable = 1'b1;
      check("no_overrun_yet", 32'(overrun_count), 32'd0);

      // Frame B: draw never completes, watchdog aborts after 16 wait cycles.
      run_clear(0);
      repeat (15) @(negedge clk);
      check("timeout_not_yet", 32'({draw_timeout, update_req}), 32'd0);
      @(negedge clk);
      check("timeout_fired", 32'({draw_timeout, update_req}), 32'({1'b1, 1'b1}));
      do_ack(2);
      check("timeout_sticky", 32'(draw_timeout), 32'd1);

      // Frames C/D: draw_done on the 15th and on the 16th wait cycle.
      do_reset();
      enable = 1'b1;
      for (int c = 15; c <= 16; c++) begin
         run_clear(0);
         repeat (c - 1) @(negedge clk);
         pulse_done();
         check("done_beats_timeout", 32'(draw_timeout), 32'd0);
         do_ack(1);
      end

      // Frame E: overruns during clear, then saturation while parked in update.
      run_clear(3);
      check("overrun_three", 32'(overrun_count), 32'd3);
      pulse_done();
      frame_tick = 1'b1;
      repeat (300) @(negedge clk);
      frame_tick = 1'b0;
      check("overrun_saturated", 32'(overrun_count), 32'd255);
      check("no_restart_on_overrun", 32'(update_req), 32'd1);
      do_ack(0);

      // Frame F: reset in the middle of the clear.
      push_clear(6);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("reset_mid_clear", 32'({plot, busy, overrun_count}), 32'd0);
      check("reset_mid_clear_writes", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Frame G: clean restart from (0,0); enable dropped mid-frame still finishes it.
      push_clear(12);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      enable = 1'b0;
      repeat (13) @(negedge clk);
      check("finish_with_enable_low", 32'(draw_start), 32'd1);
      pulse_done();
      do_ack(1);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_waits_enable", 32'(busy), 32'd0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
